// File: rtl/pixel_pkg.sv
// Shared layout for the pixel write path and the read-side splitter.
// Build macro RGB24 selects 3-byte pixels in a 32-bit word; default is RGB565 in 16 bits.
package pixel_pkg;

    localparam int unsigned PIXEL_WIDTH  = 64;
    localparam int unsigned PIXEL_HEIGHT = 32;
    localparam int unsigned COL_W        = $clog2(PIXEL_WIDTH);
    localparam int unsigned ROW_W        = $clog2(PIXEL_HEIGHT);
    localparam int unsigned ADDR_W       = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT);

`ifdef RGB24
    localparam int unsigned BYTES_PER_PIXEL       = 3;
    localparam int unsigned NUM_BITS_PER_SUBPANEL = 32;
`else
    localparam int unsigned BYTES_PER_PIXEL       = 2;
    localparam int unsigned NUM_BITS_PER_SUBPANEL = 16;
`endif

    // Byte lanes, MSB first: byte0 lands highest in the word.
    localparam int unsigned BYTE0_LSB = NUM_BITS_PER_SUBPANEL - 8;
    localparam int unsigned BYTE1_LSB = NUM_BITS_PER_SUBPANEL - 16;
`ifdef RGB24
    localparam int unsigned BYTE2_LSB = NUM_BITS_PER_SUBPANEL - 24;
`endif

    typedef logic [NUM_BITS_PER_SUBPANEL-1:0] pixel_t;
    typedef logic [8*BYTES_PER_PIXEL-1:0]     pix_bytes_t;

    typedef enum logic {StCollect, StPending} asm_state_e;

    // bytes holds the pixel in arrival order, byte0 in the top lane.
    function automatic pixel_t pack_pixel(input pix_bytes_t bytes);
        pixel_t word;
        word = '0;
        word[BYTE0_LSB +: 8] = bytes[8*BYTES_PER_PIXEL-1 -: 8];
        word[BYTE1_LSB +: 8] = bytes[8*BYTES_PER_PIXEL-9 -: 8];
`ifdef RGB24
        word[BYTE2_LSB +: 8] = bytes[7:0];
`endif
        return word;
    endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Raster {row, col} counter with column/row wrap and a last-pixel flag.
module pixel_addr_counter
    import pixel_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_last, row_last;

    assign col_last = (col_q == COL_W'(PIXEL_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(PIXEL_HEIGHT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign addr_o = {row_q, col_q};
    assign last_o = col_last & row_last;

endmodule

// File: rtl/pixel_assembler.sv
// Packs host bytes into pixel words and writes them to the framebuffer in raster order.
// PIXEL_ASSEMBLER_FRAMESTART_EN adds a frame_start input that realigns to pixel 0.
module pixel_assembler
    import pixel_pkg::*;
(
    input  logic              clk_root,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output pixel_t            fb_data,
    output logic              fb_we,
    input  logic              fb_busy,
    output logic              frame_done
`ifdef PIXEL_ASSEMBLER_FRAMESTART_EN
    ,
    input  logic              frame_start
`endif
);

    localparam int unsigned SHIFT_W = 8 * (BYTES_PER_PIXEL - 1);

    asm_state_e        state_q;
    logic [1:0]        byte_idx_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [ADDR_W-1:0] fb_addr_q;
    pixel_t            fb_data_q;
    logic              fb_last_q;

    logic              start;
    logic              accept, retire, last_byte, issue;
    pix_bytes_t        cat;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;

`ifdef PIXEL_ASSEMBLER_FRAMESTART_EN
    assign start = frame_start;
`else
    assign start = 1'b0;
`endif

    assign fb_we     = (state_q == StPending);
    assign rx_ready  = !(fb_we && fb_busy);
    assign accept    = rx_valid && rx_ready;
    assign retire    = fb_we && !fb_busy;
    assign last_byte = (byte_idx_q == 2'(BYTES_PER_PIXEL - 1));
    // A byte arriving with frame_start is byte0 of a new pixel, so it never completes one.
    assign issue     = accept && last_byte && !start;
    assign cat       = {shift_q, rx_data};

    // The counter advances on issue: the pending write keeps its own registered address,
    // and any new write can only be issued once that one retires.
    pixel_addr_counter u_addr_counter (
        .clk_i     (clk_root),
        .rst_ni    (reset),
        .clear_i   (start),
        .advance_i (issue),
        .addr_o    (cnt_addr),
        .last_o    (cnt_last)
    );

    always_ff @(posedge clk_root) begin
        if (!reset) begin
            state_q    <= StCollect;
            byte_idx_q <= '0;
            shift_q    <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_last_q  <= 1'b0;
        end else begin
            if (start) begin
                byte_idx_q <= accept ? 2'd1 : 2'd0;
                shift_q    <= accept ? cat[SHIFT_W-1:0] : '0;
            end else if (accept) begin
                byte_idx_q <= last_byte ? 2'd0 : byte_idx_q + 2'd1;
                shift_q    <= cat[SHIFT_W-1:0];
            end

            unique case (state_q)
                StCollect: begin
                    if (issue) begin
                        fb_data_q <= pack_pixel(cat);
                        fb_addr_q <= cnt_addr;
                        fb_last_q <= cnt_last;
                        state_q   <= StPending;
                    end
                end
                StPending: begin
                    if (issue) begin
                        fb_data_q <= pack_pixel(cat);
                        fb_addr_q <= cnt_addr;
                        fb_last_q <= cnt_last;
                    end else if (retire) begin
                        state_q <= StCollect;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign frame_done = retire && fb_last_q;

endmodule
